mips_multicycle_core: RTL
=========================

Name: mips_multicycle_core

Overview:
- Parametrised multicycle MIPS-subset core. It replaces the single-cycle datapath with an FSM-sequenced datapath: one shared ALU and a registered IR, A, B and ALUOut.
- Instruction and data memories are reached through req/ready handshakes, so variable-latency SRAM or wait states are supported.
- Sits at the top of the processor hierarchy and drives the instruction and data memory wrappers.
- Exposes a register-file write port for testbench scoreboarding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RF_DEPTH, 32, number of general registers (power of 2, 8..32). Register index = low log2(RF_DEPTH) bits of the instruction field.
- DMEM_AW, 7, data memory word-address width. dmem_addr = ALUOut[DMEM_AW+1:2].
- JAL_LINK_REG, 31, register written by jal. Must be < RF_DEPTH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  byte address of fetch (= PC)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write (sw), 0 = read (lw)
- dmem_addr  out  DMEM_AW  word address
- dmem_wdata  out  32  store data (B register)
- dmem_ready  in  1  access complete; dmem_rdata valid for reads
- dmem_rdata  in  32  load data
- rf_wr_valid  out  1  one-cycle pulse on every register-file write
- rf_wr_addr  out  5  destination register index
- rf_wr_data  out  32  written value
- illegal  out  1  sticky: unsupported opcode/funct decoded

Behaviour:
- Reset (async, any state):
  - PC=RESET_PC; state=FETCH.
  - IR, A, B, ALUOut and all registers cleared.
  - All outputs 0 except imem_addr=RESET_PC.
  - If reset asserts mid-handshake, req drops immediately. No write completes.
- Supported instructions:
  - R-type (op 0): add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), jr 001000.
  - lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else -> illegal.
- Register file:
  - RF_DEPTH x 32, two combinational read ports, one synchronous write port.
  - Register 0 always reads 0. Writes to 0 are discarded but still pulse rf_wr_valid with addr 0.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_ready.
  - On imem_ready: IR<=imem_rdata, PC<=PC+4, go to DECODE.
  - imem_ready while req=0 is ignored.
- DECODE:
  - A<=R[rs], B<=R[rt]; ALUOut<=PC+(signext(imm)<<2) as the branch target.
  - j: PC<={PC[31:28],IR[25:0],2'b00}, go to FETCH.
  - jal: same PC update, plus write R[JAL_LINK_REG]<=PC (already +4), go to FETCH.
  - jr: PC<=R[rs], go to FETCH.
  - illegal: set illegal, go to HALT.
  - All other instructions go to EXEC.
- EXEC:
  - R-type: ALUOut<=A op B, go to WB.
  - lw/sw: ALUOut<=A+signext(imm), go to MEM.
  - beq: if A==B then PC<=ALUOut; go to FETCH either way.
- MEM:
  - dmem_req=1; dmem_we=(sw); addr and wdata held stable until dmem_ready.
  - sw + ready: go to FETCH.
  - lw + ready: MDR<=dmem_rdata, go to WB.
  - Address bits [1:0] are ignored.
- WB:
  - R-type writes R[rd]<=ALUOut; lw writes R[rt]<=MDR.
  - rf_wr_valid=1 for this one cycle; go to FETCH.
- HALT: terminal. All req=0, illegal=1, until reset.
- Cycle counts with zero-wait memory (ready in the same cycle req rises):
  - j/jal/jr: 2
  - beq: 3
  - R-type: 4
  - sw: 4
  - lw: 5
- Each wait cycle on imem or dmem adds exactly 1 cycle.
- All arithmetic is 32-bit modulo 2^32. PC wraps past 32'hFFFF_FFFC to 0.

Test Plan:
- Reset, then imem_ready held high with add $3,$1,$2 (R1=5, R2=7 preloaded via lw) -> rf_wr_valid with addr 3, data 12, on the 4th cycle after fetch start; imem_addr sequence 0,4,8.
- sw $3,8($0) then lw $4,8($0), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with addr=2 and wdata=12 stable; R4=12; lw takes 8 cycles total.
- beq $1,$1,-1 -> PC returns to its own address. beq with unequal operands -> PC+4. Both take 3 cycles.
- jal to 0x40 from PC 0x10 -> R31=0x14, next imem_addr=0x40. Then jr $31 -> next imem_addr=0x14.
- add $0,$1,$2 -> rf_wr_valid pulses with addr 0, and a later read of $0 returns 0. slt with -1 vs 1 -> 1.
- Opcode 6'b111111 -> illegal=1, no further imem_req. Separately, assert rst_n mid-MEM of sw -> dmem_req drops asynchronously, PC=RESET_PC, memory is not written.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FSM-sequenced datapath with one shared ALU and
// registered IR/A/B/ALUOut/MDR, talking to instruction/data memories via req/ready.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          RF_DEPTH     = 32,
    parameter int          DMEM_AW      = 7,
    parameter int          JAL_LINK_REG = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ready,
    input  logic [31:0]        dmem_rdata,
    output logic               rf_wr_valid,
    output logic [4:0]         rf_wr_addr,
    output logic [31:0]        rf_wr_data,
    output logic               illegal
);
    localparam int RAW = $clog2(RF_DEPTH);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rf_q [RF_DEPTH];

    logic [5:0]     opcode, funct;
    logic [RAW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]    imm_se, br_off, rd_a, rd_b;
    logic           is_r, is_jr, is_lw, is_sw, is_beq, is_j, is_jal, is_legal;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [31:0]    rf_wdata;

    function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] f);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        case (f)
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_AND:   r = a & b;
            F_OR:    r = a | b;
            F_SLT:   r = {31'd0, sa < sb};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs_idx = ir_q[21 +: RAW];
    assign rt_idx = ir_q[16 +: RAW];
    assign rd_idx = ir_q[11 +: RAW];
    assign imm_se = {{16{ir_q[15]}}, ir_q[15:0]};
    assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    assign is_r   = (opcode == OP_RTYPE) &&
                    (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                     funct == F_OR  || funct == F_SLT);
    assign is_jr  = (opcode == OP_RTYPE) && (funct == F_JR);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_beq = (opcode == OP_BEQ);
    assign is_j   = (opcode == OP_J);
    assign is_jal = (opcode == OP_JAL);
    assign is_legal = is_r | is_jr | is_lw | is_sw | is_beq | is_j | is_jal;

    assign rd_a = (rs_idx == '0) ? 32'd0 : rf_q[rs_idx];
    assign rd_b = (rt_idx == '0) ? 32'd0 : rf_q[rt_idx];

    // jal links in DECODE; R-type and lw write back in WB
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = 32'd0;
        if (state_q == S_DECODE && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = RAW'(JAL_LINK_REG);
            rf_wdata = pc_q;
        end else if (state_q == S_WB) begin
            rf_we    = 1'b1;
            rf_waddr = is_lw ? rt_idx : rd_idx;
            rf_wdata = is_lw ? mdr_q : alu_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rd_a;
                b_d   = rd_b;
                alu_d = pc_q + br_off;
                if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_j || is_jal) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_d    = rd_a;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_d   = alu_op(a_q, b_q, funct);
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_d   = a_q + imm_se;
                    state_d = S_MEM;
                end else begin
                    if (a_q == b_q) pc_d = alu_q;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (is_lw) begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_waddr != '0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // imem_req is gated by rst_n so every output except imem_addr is 0 during reset
    assign imem_req    = rst_n && (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = dmem_req && is_sw;
    assign dmem_addr   = alu_q[DMEM_AW+1:2];
    assign dmem_wdata  = b_q;
    assign rf_wr_valid = rf_we;
    assign rf_wr_addr  = 5'(rf_waddr);
    assign rf_wr_data  = rf_wdata;
    assign illegal     = illegal_q;

endmodule
